dec_ex_interlock_stage: RTL
===========================

Name: dec_ex_interlock_stage

Overview:
- DECODE→EX pipeline register with load-use interlock.
- Captures decoded instruction fields and the RS/RT operands after forwarding, and presents them to EX.
- EX-stage results of loads are not forwardable, so the block detects DEC instructions that read a load destination currently in EX. For those it stalls DECODE one cycle and injects a bubble.
- Also handles branch flush and downstream EX stall, and keeps a saturating bubble counter for performance monitoring.

Parameters:
- DATA_WIDTH, 32, operand/immediate/PC width
- REG_ADDR_WIDTH, 5, register address width
- CTRL_WIDTH, 16, opaque ALU/MEM control bundle width
- CNT_WIDTH, 16, bubble counter width

Ports:
- i_Clk  in  1  clock; all state updates on rising edge
- i_Reset_n  in  1  reset, asynchronous and active-low
- i_DEC_Valid  in  1  DECODE holds a valid instruction
- i_DEC_Uses_RS  in  1  instruction reads RS
- i_DEC_RS_Addr  in  REG_ADDR_WIDTH  RS address
- i_DEC_Uses_RT  in  1  instruction reads RT
- i_DEC_RT_Addr  in  REG_ADDR_WIDTH  RT address
- i_DEC_RS_Data  in  DATA_WIDTH  RS operand, already forwarded
- i_DEC_RT_Data  in  DATA_WIDTH  RT operand, already forwarded
- i_DEC_Imm  in  DATA_WIDTH  sign/zero-extended immediate
- i_DEC_PC  in  DATA_WIDTH  instruction PC
- i_DEC_Ctrl  in  CTRL_WIDTH  control bundle
- i_DEC_Writes_Back  in  1  instruction writes a register
- i_DEC_Write_Addr  in  REG_ADDR_WIDTH  destination register
- i_DEC_Is_Load  in  1  instruction is a load
- i_EX_Stall  in  1  EX cannot accept a new instruction; hold
- i_Flush  in  1  squash DEC→EX contents (taken branch/redirect)
- o_DEC_Stall  out  1  hold IFetch/DECODE this cycle
- o_EX_Valid  out  1  EX holds a valid instruction
- o_EX_RS_Data, o_EX_RT_Data, o_EX_Imm, o_EX_PC  out  DATA_WIDTH  latched fields
- o_EX_Ctrl  out  CTRL_WIDTH  latched control
- o_EX_Writes_Back  out  1  latched writeback flag, qualified by o_EX_Valid
- o_EX_Write_Addr  out  REG_ADDR_WIDTH  latched destination
- o_EX_Is_Load  out  1  latched load flag
- o_EX_Fwd_Valid  out  1  EX result forwardable; equals o_EX_Valid & ~o_EX_Is_Load
- o_Bubble_Count  out  CNT_WIDTH  count of interlock bubbles, saturating

Behaviour:
- Reset (asynchronous, i_Reset_n=0): all outputs 0, including o_EX_Valid, o_EX_Writes_Back, o_EX_Is_Load and o_Bubble_Count.
- hazard (combinational) = i_DEC_Valid & o_EX_Valid & o_EX_Is_Load & o_EX_Writes_Back & (o_EX_Write_Addr != 0) & ((i_DEC_Uses_RS & i_DEC_RS_Addr == o_EX_Write_Addr) | (i_DEC_Uses_RT & i_DEC_RT_Addr == o_EX_Write_Addr)).
- o_DEC_Stall (combinational) = ~i_Flush & (hazard | i_EX_Stall).
- Per-edge priority:
  1. i_Flush: o_EX_Valid←0, o_EX_Writes_Back←0, o_EX_Is_Load←0; other fields don't-care. Flush overrides i_EX_Stall.
  2. i_EX_Stall: all EX registers hold. No bubble is counted.
  3. hazard: bubble; o_EX_Valid←0, o_EX_Writes_Back←0, o_EX_Is_Load←0. DEC holds through o_DEC_Stall. o_Bubble_Count increments unless all-ones.
  4. Otherwise advance: all fields latched from DEC. o_EX_Valid←i_DEC_Valid; o_EX_Writes_Back←i_DEC_Writes_Back & i_DEC_Valid; o_EX_Is_Load←i_DEC_Is_Load & i_DEC_Valid.
- Latency: 1 cycle DEC→EX when no hazard. A load-use pair costs exactly one bubble. Next cycle the load is in MEM and the operand arrives through MEM forwarding.
- Back-to-back loads to the same register: each dependent consumer stalls independently, one cycle each.
- Register 0 never causes a hazard.
- An invalid DEC never causes a hazard or a count.
- Counter saturates at 2^CNT_WIDTH−1 with no wrap. It is cleared only by reset.
- Reset asserted mid-stall clears the bubble and valid state immediately. o_DEC_Stall drops to 0 asynchronously because o_EX_Valid=0.

Test Plan:
- Reset: assert i_Reset_n=0 mid-cycle with o_EX_Valid=1 → all outputs 0 before the next edge; o_Bubble_Count=0.
- Load-use: EX holds load r5 (Is_Load=1, WA=5); DEC add reads RS=5 → o_DEC_Stall=1 for 1 cycle, EX gets bubble (o_EX_Valid=0), o_Bubble_Count 0→1. The next edge latches the add with Valid=1.
- No hazard: EX load r5, DEC reads RS=6, RT=7, or reads RT=5 with Uses_RT=0 → no stall; add latched next edge with its RS/RT data (e.g. 0xDEADBEEF/0x12345678) unchanged. EX ALU op writing r5 with DEC reading r5 → no stall, o_EX_Fwd_Valid=1.
- Register 0: EX load WA=0, DEC RS=0 → no stall, count unchanged.
- Flush priority: i_Flush=1 together with hazard and i_EX_Stall=1 → o_DEC_Stall=0; next edge o_EX_Valid=0, count unchanged.
- EX stall: i_EX_Stall=1 for 3 cycles → EX fields frozen (PC=0x00400010 stays), o_DEC_Stall=1, count unchanged. Counter preloaded to 0xFFFF plus another hazard → stays 0xFFFF.

Source files
------------

// File: rtl/dec_ex_interlock_stage.sv
// DECODE->EX pipeline register with load-use interlock.
// Captures the decoded fields and forwarded RS/RT operands of the DECODE
// instruction and presents them to EX one cycle later. A load in EX cannot
// forward its result, so a DECODE instruction reading that load's destination
// is held for one cycle while a bubble is sent into EX. Branch flush and a
// downstream EX stall are also handled. A saturating counter tracks bubbles.
//
// Ports:
//   i_Clk, i_Reset_n       clock, asynchronous active-low reset
//   i_DEC_*                decoded instruction, operands, writeback/load info
//   i_EX_Stall             EX cannot accept a new instruction; hold EX
//   i_Flush                squash the DEC->EX contents
//   o_DEC_Stall            combinational hold request to IFetch/DECODE
//   o_EX_*                 registered EX-stage instruction fields
//   o_EX_Fwd_Valid         EX result forwardable (valid, not a load)
//   o_Bubble_Count         saturating count of interlock bubbles
module dec_ex_interlock_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CTRL_WIDTH     = 16,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset_n,
    input  logic                      i_DEC_Valid,
    input  logic                      i_DEC_Uses_RS,
    input  logic [REG_ADDR_WIDTH-1:0] i_DEC_RS_Addr,
    input  logic                      i_DEC_Uses_RT,
    input  logic [REG_ADDR_WIDTH-1:0] i_DEC_RT_Addr,
    input  logic [DATA_WIDTH-1:0]     i_DEC_RS_Data,
    input  logic [DATA_WIDTH-1:0]     i_DEC_RT_Data,
    input  logic [DATA_WIDTH-1:0]     i_DEC_Imm,
    input  logic [DATA_WIDTH-1:0]     i_DEC_PC,
    input  logic [CTRL_WIDTH-1:0]     i_DEC_Ctrl,
    input  logic                      i_DEC_Writes_Back,
    input  logic [REG_ADDR_WIDTH-1:0] i_DEC_Write_Addr,
    input  logic                      i_DEC_Is_Load,
    input  logic                      i_EX_Stall,
    input  logic                      i_Flush,
    output logic                      o_DEC_Stall,
    output logic                      o_EX_Valid,
    output logic [DATA_WIDTH-1:0]     o_EX_RS_Data,
    output logic [DATA_WIDTH-1:0]     o_EX_RT_Data,
    output logic [DATA_WIDTH-1:0]     o_EX_Imm,
    output logic [DATA_WIDTH-1:0]     o_EX_PC,
    output logic [CTRL_WIDTH-1:0]     o_EX_Ctrl,
    output logic                      o_EX_Writes_Back,
    output logic [REG_ADDR_WIDTH-1:0] o_EX_Write_Addr,
    output logic                      o_EX_Is_Load,
    output logic                      o_EX_Fwd_Valid,
    output logic [CNT_WIDTH-1:0]      o_Bubble_Count
);

    logic                      ex_valid_q, ex_valid_d;
    logic                      ex_wb_q,    ex_wb_d;
    logic                      ex_load_q,  ex_load_d;
    logic                      ex_fwd_q,   ex_fwd_d;
    logic [REG_ADDR_WIDTH-1:0] ex_wa_q,    ex_wa_d;
    logic [DATA_WIDTH-1:0]     ex_rs_q,    ex_rs_d;
    logic [DATA_WIDTH-1:0]     ex_rt_q,    ex_rt_d;
    logic [DATA_WIDTH-1:0]     ex_imm_q,   ex_imm_d;
    logic [DATA_WIDTH-1:0]     ex_pc_q,    ex_pc_d;
    logic [CTRL_WIDTH-1:0]     ex_ctrl_q,  ex_ctrl_d;
    logic [CNT_WIDTH-1:0]      bubble_cnt_q, bubble_cnt_d;

    logic load_dest_c;
    logic rs_hit_c;
    logic rt_hit_c;
    logic hazard_c;

    // Load-use detection: EX holds a live load to a nonzero register that DEC reads.
    always_comb begin
        load_dest_c = ex_valid_q & ex_load_q & ex_wb_q & (ex_wa_q != '0);
        rs_hit_c    = i_DEC_Uses_RS & (i_DEC_RS_Addr == ex_wa_q);
        rt_hit_c    = i_DEC_Uses_RT & (i_DEC_RT_Addr == ex_wa_q);
        hazard_c    = i_DEC_Valid & load_dest_c & (rs_hit_c | rt_hit_c);
    end

    // Flush wins over everything, so a redirect never holds DECODE.
    assign o_DEC_Stall = ~i_Flush & (hazard_c | i_EX_Stall);

    // Next-state: flush > EX stall > bubble > advance.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_wb_d      = ex_wb_q;
        ex_load_d    = ex_load_q;
        ex_wa_d      = ex_wa_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_imm_d     = ex_imm_q;
        ex_pc_d      = ex_pc_q;
        ex_ctrl_d    = ex_ctrl_q;
        bubble_cnt_d = bubble_cnt_q;

        if (i_Flush) begin
            ex_valid_d = 1'b0;
            ex_wb_d    = 1'b0;
            ex_load_d  = 1'b0;
        end else if (i_EX_Stall) begin
            // hold all EX state
        end else if (hazard_c) begin
            ex_valid_d = 1'b0;
            ex_wb_d    = 1'b0;
            ex_load_d  = 1'b0;
            if (bubble_cnt_q != {CNT_WIDTH{1'b1}}) begin
                bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
            end
        end else begin
            ex_valid_d = i_DEC_Valid;
            ex_wb_d    = i_DEC_Writes_Back & i_DEC_Valid;
            ex_load_d  = i_DEC_Is_Load & i_DEC_Valid;
            ex_wa_d    = i_DEC_Write_Addr;
            ex_rs_d    = i_DEC_RS_Data;
            ex_rt_d    = i_DEC_RT_Data;
            ex_imm_d   = i_DEC_Imm;
            ex_pc_d    = i_DEC_PC;
            ex_ctrl_d  = i_DEC_Ctrl;
        end

        // Registered alongside valid/load so the flag needs no output logic.
        ex_fwd_d = ex_valid_d & ~ex_load_d;
    end

    // EX pipeline register and bubble counter.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ex_valid_q   <= 1'b0;
            ex_wb_q      <= 1'b0;
            ex_load_q    <= 1'b0;
            ex_fwd_q     <= 1'b0;
            ex_wa_q      <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_imm_q     <= '0;
            ex_pc_q      <= '0;
            ex_ctrl_q    <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_wb_q      <= ex_wb_d;
            ex_load_q    <= ex_load_d;
            ex_fwd_q     <= ex_fwd_d;
            ex_wa_q      <= ex_wa_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc_q      <= ex_pc_d;
            ex_ctrl_q    <= ex_ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign o_EX_Valid       = ex_valid_q;
    assign o_EX_Writes_Back = ex_wb_q;
    assign o_EX_Is_Load     = ex_load_q;
    assign o_EX_Fwd_Valid   = ex_fwd_q;
    assign o_EX_Write_Addr  = ex_wa_q;
    assign o_EX_RS_Data     = ex_rs_q;
    assign o_EX_RT_Data     = ex_rt_q;
    assign o_EX_Imm         = ex_imm_q;
    assign o_EX_PC          = ex_pc_q;
    assign o_EX_Ctrl        = ex_ctrl_q;
    assign o_Bubble_Count   = bubble_cnt_q;

endmodule
